// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder backing-store model.
// Used by mem_responder and mem_resp_array.
package mem_resp_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 5;
  localparam int LATENCY_DEF = 3;

  // Completion counters are fixed at 16 bits and stick at all-ones.
  localparam int          STAT_W   = 16;
  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Saturating increment for the completion counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (value == STAT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// DEPTH x DATA_W word store with one write port and one registered read port.
// Every word and the read register clear on reset, so the store is built
// from flops rather than a RAM macro. A single commit strobe either writes
// the word (and echoes it on rdata) or registers the addressed word onto rdata.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              commit,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // One flop row per word; a row loads only when a committed write targets it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        mem_reg[gi] <= '0;
      end else if (commit && we && (addr == ADDR_W'(gi))) begin
        mem_reg[gi] <= wdata;
      end
    end
  end

  // Registered read port: a write echoes its own data, a read returns the word.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rdata_reg <= '0;
    end else if (commit) begin
      rdata_reg <= we ? wdata : mem_reg[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_responder.sv
// Slow main-memory responder: accepts one request at a time from IDLE,
// waits LATENCY cycles, commits to the word store, then pulses ack for one
// cycle. Optional completion counters are built only when the macro
// MEM_RESP_STATS_EN is defined; otherwise rd_count/wr_count read as zero.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  // Wide enough to hold LATENCY-1; reloaded at every acceptance so it never wraps.
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               we_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic               accept;
  logic               commit;

  assign accept = (state_reg == IDLE) && req;
  assign commit = (state_reg == WAIT) && (cnt_reg == '0);

  // State and latency counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and counter logic: IDLE -> WAIT -> RESP -> IDLE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          state_next = WAIT;
          cnt_next   = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture: inputs are frozen at acceptance and ignored while busy.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      we_reg    <= we;
      addr_reg  <= addr;
      wdata_reg <= wdata;
    end
  end

  mem_resp_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clock  (clock),
    .resetn (resetn),
    .commit (commit),
    .we     (we_reg),
    .addr   (addr_reg),
    .wdata  (wdata_reg),
    .rdata  (rdata)
  );

  // Decoded from the state so that reset removes both immediately.
  assign ack  = (state_reg == RESP);
  assign busy = (state_reg != IDLE);

`ifdef MEM_RESP_STATS_EN
  logic [STAT_W-1:0] rd_count_reg;
  logic [STAT_W-1:0] wr_count_reg;

  // Count completions on the ack cycle, split by the captured direction.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_count_reg <= '0;
      wr_count_reg <= '0;
    end else if (ack) begin
      if (we_reg) begin
        wr_count_reg <= sat_inc(wr_count_reg);
      end else begin
        rd_count_reg <= sat_inc(rd_count_reg);
      end
    end
  end

  assign rd_count = rd_count_reg;
  assign wr_count = wr_count_reg;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (default parameters, LATENCY=3).
// Reference model: a plain word array plus read/write tallies, updated in
// request order; expected ack timing is computed from the latency rule.
module tb_mem_responder;

  localparam int L = 3;

  logic        clock;
  logic        resetn;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;
  logic        busy;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int n_cmp;
  int n_bad;

  logic [15:0] model_mem [32];
  int          model_rd;
  int          model_wr;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  mem_responder dut (
    .clock    (clock),
    .resetn   (resetn),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model of one request: the value the ack must carry.
  task automatic model_access(input logic m_we, input logic [4:0] m_addr,
                              input logic [15:0] m_wdata, output logic [15:0] exp_data);
    if (m_we) begin
      model_mem[m_addr] = m_wdata;
      model_wr++;
      exp_data = m_wdata;
    end else begin
      model_rd++;
      exp_data = model_mem[m_addr];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
    model_rd = 0;
    model_wr = 0;
  endtask

  // Issue one request from IDLE (called at a negedge) and observe it for
  // L+2 cycles; inputs are scrambled once the request is accepted.
  task automatic run_txn(input logic t_we, input logic [4:0] t_addr, input logic [15:0] t_wdata,
                         output int ack_cyc, output logic [15:0] ack_data,
                         output int n_ack, output int busy_bad);
    ack_cyc  = -1;
    ack_data = '0;
    n_ack    = 0;
    busy_bad = 0;
    req   = 1'b1;
    we    = t_we;
    addr  = t_addr;
    wdata = t_wdata;
    @(posedge clock);
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clock);
      req   = 1'b0;
      we    = 1'($urandom);
      addr  = 5'($urandom);
      wdata = 16'($urandom);
      if (ack === 1'b1) begin
        n_ack++;
        if (ack_cyc < 0) begin
          ack_cyc  = k;
          ack_data = rdata;
        end
      end
      if (busy !== (k <= L + 1)) busy_bad++;
    end
    $display("txn we=%0d addr=%0d wdata=%h -> ack_cycle=%0d rdata=%h acks=%0d",
             t_we, t_addr, t_wdata, ack_cyc, ack_data, n_ack);
  endtask

  // Run a request and compare timing, busy window and data against the model.
  task automatic checked_txn(input string tag, input logic t_we, input logic [4:0] t_addr,
                             input logic [15:0] t_wdata);
    int          ack_cyc, n_ack, busy_bad;
    logic [15:0] ack_data, exp_data;
    model_access(t_we, t_addr, t_wdata, exp_data);
    run_txn(t_we, t_addr, t_wdata, ack_cyc, ack_data, n_ack, busy_bad);
    n_cmp++;
    if (ack_cyc !== L + 1) begin
      n_bad++;
      $display("FAIL %s ack_cycle: got %0d expected %0d", tag, ack_cyc, L + 1);
    end
    n_cmp++;
    if (n_ack !== 1) begin
      n_bad++;
      $display("FAIL %s ack_pulses: got %0d expected 1", tag, n_ack);
    end
    n_cmp++;
    if (busy_bad !== 0) begin
      n_bad++;
      $display("FAIL %s busy_window: got %0d wrong cycles expected 0", tag, busy_bad);
    end
    n_cmp++;
    if (ack_data !== exp_data) begin
      n_bad++;
      $display("FAIL %s rdata: got %h expected %h", tag, ack_data, exp_data);
    end
  endtask

  task automatic test_reset();
    req    = 1'b0;
    we     = 1'b0;
    addr   = '0;
    wdata  = '0;
    resetn = 1'b0;
    model_clear();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0", ack); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++;
    if (rdata !== 16'h0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0000", rdata); end
    n_cmp++;
    if (rd_count !== 16'h0) begin n_bad++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count); end
    n_cmp++;
    if (wr_count !== 16'h0) begin n_bad++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count); end
  endtask

  task automatic test_first_read();
    checked_txn("first_read", 1'b0, 5'd5, 16'h0);
  endtask

  task automatic test_write_read();
    checked_txn("write_7", 1'b1, 5'd7, 16'hBEEF);
    checked_txn("read_7", 1'b0, 5'd7, 16'h0);
    // rdata must hold after the ack has gone.
    @(negedge clock);
    n_cmp++;
    if (rdata !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL rdata_hold: got %h expected BEEF", rdata);
    end
  endtask

  task automatic test_latched_inputs();
    // run_txn scrambles we/addr/wdata during WAIT; the response must still
    // reflect what was presented at acceptance.
    checked_txn("latched_wr", 1'b1, 5'd12, 16'h1357);
    checked_txn("latched_rd", 1'b0, 5'd12, 16'h0);
    checked_txn("latched_rd2", 1'b0, 5'd13, 16'hFFFF);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      checked_txn("random", 1'($urandom), 5'($urandom_range(7, 0)), 16'($urandom));
    end
  endtask

  // req held high: a new request is accepted whenever the responder is free
  // again, i.e. every L+2 cycles, each acked L+1 cycles after acceptance.
  task automatic test_back_to_back();
    exp_t        q[$];
    exp_t        e;
    int          free_cyc;
    int          n_pushed;
    int          n_seen;
    logic [15:0] exp_data;
    free_cyc = 0;
    n_pushed = 0;
    n_seen   = 0;
    for (int c = 0; c <= 46; c++) begin
      if (q.size() > 0 && q[0].cyc == c) begin
        e = q.pop_front();
        n_cmp++;
        if (ack !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_ack cycle %0d: got %b expected 1", c, ack);
        end else begin
          n_seen++;
          n_cmp++;
          if (rdata !== e.data) begin
            n_bad++;
            $display("FAIL b2b_rdata cycle %0d: got %h expected %h", c, rdata, e.data);
          end
        end
      end else if (ack === 1'b1) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b2b_spurious_ack cycle %0d: got 1 expected 0", c);
      end
      if (c < 40) begin
        req   = 1'b1;
        we    = 1'($urandom);
        addr  = (c % 2 == 1) ? 5'd9 : 5'd22;
        wdata = 16'($urandom);
        if (c >= free_cyc) begin
          model_access(we, addr, wdata, exp_data);
          e.cyc  = c + L + 1;
          e.data = exp_data;
          q.push_back(e);
          free_cyc = c + L + 2;
          n_pushed++;
        end
      end else begin
        req = 1'b0;
      end
      @(negedge clock);
    end
    $display("b2b requests=%0d acks_seen=%0d", n_pushed, n_seen);
    n_cmp++;
    if (n_seen !== 8) begin
      n_bad++;
      $display("FAIL b2b_ack_count: got %0d expected 8", n_seen);
    end
  endtask

  // Reset during WAIT of a write: the write is lost and earlier data cleared.
  task automatic test_reset_mid();
    int n_ack;
    checked_txn("pre_write_3", 1'b1, 5'd3, 16'h1234);
    req   = 1'b1;
    we    = 1'b1;
    addr  = 5'd3;
    wdata = 16'h5678;
    @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    #1;
    model_clear();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_cmp++;
    if (ack !== 1'b0) begin n_bad++; $display("FAIL midreset_ack: got %b expected 0", ack); end
    @(negedge clock);
    resetn = 1'b1;
    n_ack = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (ack === 1'b1) n_ack++;
    end
    $display("txn reset-mid write addr=3 -> acks after reset=%0d", n_ack);
    n_cmp++;
    if (n_ack !== 0) begin n_bad++; $display("FAIL midreset_no_ack: got %0d expected 0", n_ack); end
    checked_txn("read_3_after_reset", 1'b0, 5'd3, 16'h0);
  endtask

  task automatic test_stats();
    int exp_rd, exp_wr;
    // One read already done since the last reset; complete 3 reads, 2 writes.
    checked_txn("stats_rd", 1'b0, 5'd1, 16'h0);
    checked_txn("stats_wr", 1'b1, 5'd2, 16'hA5A5);
    checked_txn("stats_wr", 1'b1, 5'd4, 16'h5A5A);
    checked_txn("stats_rd", 1'b0, 5'd2, 16'h0);
`ifdef MEM_RESP_STATS_EN
    exp_rd = model_rd;
    exp_wr = model_wr;
`else
    exp_rd = 0;
    exp_wr = 0;
`endif
    $display("stats rd_count=%0d wr_count=%0d", rd_count, wr_count);
    n_cmp++;
    if (rd_count !== 16'(exp_rd)) begin
      n_bad++;
      $display("FAIL stats_rd_count: got %0d expected %0d", rd_count, exp_rd);
    end
    n_cmp++;
    if (wr_count !== 16'(exp_wr)) begin
      n_bad++;
      $display("FAIL stats_wr_count: got %0d expected %0d", wr_count, exp_wr);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_first_read();
    test_write_read();
    test_latched_inputs();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
